// File: rtl/serial_adder_seq.sv
// serial_adder_seq: bit-serial WIDTH-bit adder, one bit per clock, LSB first.
// Operands are latched on the accepting edge; sum/carry_out are registered
// and change only on completion (done pulse) or reset.
module serial_adder_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    // Counter needs at least one bit even when WIDTH=1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sa_q, sb_q, r_q, sum_q;
    logic             c_q, busy_q, done_q, carry_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH-1:0] sa_d, sb_d, r_d;
    logic             c_d, bit_s, last_s;
    logic [CW-1:0]    cnt_d;

    // One half-adder pair per bit: sum bit, next carry, and the shifted state.
    always_comb begin
        bit_s          = sa_q[0] ^ sb_q[0] ^ c_q;
        c_d            = (sa_q[0] & sb_q[0]) | (c_q & (sa_q[0] ^ sb_q[0]));
        sa_d           = sa_q >> 1;
        sb_d           = sb_q >> 1;
        r_d            = r_q >> 1;
        r_d[WIDTH-1]   = bit_s;
        cnt_d          = cnt_q + CW'(1);
        last_s         = (cnt_q == CW'(WIDTH - 1));
    end

    // Control FSM and datapath registers; all outputs come straight from flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            r_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sa_q    <= a;
                        sb_q    <= b;
                        r_q     <= '0;
                        c_q     <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    sa_q  <= sa_d;
                    sb_q  <= sb_d;
                    r_q   <= r_d;
                    c_q   <= c_d;
                    cnt_q <= cnt_d;
                    if (last_s) begin
                        // Publish the result including the bit processed this edge.
                        sum_q   <= r_d;
                        carry_q <= c_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign carry_out = carry_q;

endmodule
